// File: rtl/or_bus_arbiter_4_if.sv
// Bus bundle for the four-requester OR-bus arbiter: request/data inputs,
// grant and registered bus word back, plus the bubble-mask config port.
interface or_bus_arbiter_4_if #(
    parameter int unsigned NrOfBits = 8
);
    logic [3:0]          req;
    logic [NrOfBits-1:0] data1;
    logic [NrOfBits-1:0] data2;
    logic [NrOfBits-1:0] data3;
    logic [NrOfBits-1:0] data4;
    logic                cfg_we;
    logic [3:0]          cfg_mask;
    logic [3:0]          grant;
    logic                bus_valid;
    logic [NrOfBits-1:0] bus_data;
    logic                cfg_err;

    modport master (
        output req, data1, data2, data3, data4, cfg_we, cfg_mask,
        input  grant, bus_valid, bus_data, cfg_err
    );

    modport slave (
        input  req, data1, data2, data3, data4, cfg_we, cfg_mask,
        output grant, bus_valid, bus_data, cfg_err
    );
endinterface

// File: rtl/or_bus_arbiter_4.sv
// Round-robin arbiter for a shared OR bus: one owner at a time, burst-limited
// tenures, per-input bubble mask and a registered bus word.
module or_bus_arbiter_4 #(
    parameter int unsigned NrOfBits = 8,
    parameter int unsigned MaxBurst = 4
) (
    input logic                clock,
    input logic                reset_n,
    or_bus_arbiter_4_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0] MaxCnt = 4'(MaxBurst);

    state_e              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [3:0]          mask_q, mask_d;
    logic                valid_q, valid_d;
    logic [NrOfBits-1:0] data_q, data_d;
    logic                err_q, err_d;

    logic [NrOfBits-1:0] din [4];
    logic [1:0]          owner;
    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          scan_idx;
    logic                rearb;
    logic                cfg_ok;

    assign din[0] = bus.data1;
    assign din[1] = bus.data2;
    assign din[2] = bus.data3;
    assign din[3] = bus.data4;

    // Rotating scan starting at ptr_q; the current owner sits at ptr_q-1,
    // so it is naturally the last candidate when its tenure ends.
    always_comb begin
        owner     = 2'd0;
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) owner = 2'(i);
        end
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rearb   = 1'b0;
        unique case (state_q)
            StIdle: rearb = 1'b1;
            StBusy: begin
                if (bus.req[owner] && (cnt_q < MaxCnt)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    rearb = 1'b1;
                end
            end
            default: rearb = 1'b1;
        endcase
        if (rearb) begin
            if (win_found) begin
                state_d = StBusy;
                grant_d = 4'b0001 << win_idx;
                cnt_d   = 4'd1;
                ptr_d   = win_idx + 2'd1;
            end else begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        end
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) data_d = data_d | (din[i] ^ {NrOfBits{mask_q[i]}});
        end
        valid_d = |grant_q;
    end

    // Mask may only change while the bus is quiet, so no tenure sees a mix.
    always_comb begin
        cfg_ok = bus.cfg_we && (state_q == StIdle) && (bus.req == 4'b0000);
        mask_d = cfg_ok ? bus.cfg_mask : mask_q;
        err_d  = bus.cfg_we && !cfg_ok;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd0;
            mask_q  <= 4'b0000;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_data  = data_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_or_bus_arbiter_4.sv
// Directed and randomized checks of or_bus_arbiter_4 against a tenure-level
// reference model (owner index, burst count, rotating priority).
module tb_or_bus_arbiter_4;
    localparam int unsigned NrOfBits = 8;
    localparam int unsigned MaxBurst = 4;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    or_bus_arbiter_4_if #(.NrOfBits(NrOfBits)) bif ();

    or_bus_arbiter_4 #(
        .NrOfBits(NrOfBits),
        .MaxBurst(MaxBurst)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: owner -1 means nobody holds the bus.
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    logic [3:0]  m_mask;
    logic [3:0]  e_grant;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_err;

    function automatic logic [7:0] din(input int i);
        case (i)
            0:       return bif.data1;
            1:       return bif.data2;
            2:       return bif.data3;
            default: return bif.data4;
        endcase
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_mask  = 4'b0000;
        e_grant = 4'b0000;
        e_valid = 1'b0;
        e_data  = 8'h00;
        e_err   = 1'b0;
    endfunction

    function automatic void model_edge();
        int winner;
        int c;
        e_valid = (m_owner >= 0);
        e_data  = 8'h00;
        if (m_owner >= 0) e_data = din(m_owner) ^ (m_mask[m_owner] ? 8'hFF : 8'h00);
        e_err = 1'b0;
        if (bif.cfg_we) begin
            if (m_owner < 0 && bif.req == 4'b0000) m_mask = bif.cfg_mask;
            else e_err = 1'b1;
        end
        if (m_owner >= 0 && bif.req[m_owner] && m_cnt < int'(MaxBurst)) begin
            m_cnt = m_cnt + 1;
        end else begin
            winner = -1;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (winner < 0 && bif.req[c]) winner = c;
            end
            if (winner >= 0) begin
                m_owner = winner;
                m_cnt   = 1;
                m_ptr   = (winner + 1) % 4;
            end else begin
                m_owner = -1;
            end
        end
        e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"}, 32'(bif.grant), 32'(e_grant));
        check({tag, ".valid"}, 32'(bif.bus_valid), 32'(e_valid));
        check({tag, ".data"}, 32'(bif.bus_data), 32'(e_data));
        check({tag, ".err"}, 32'(bif.cfg_err), 32'(e_err));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        bif.req    = 4'b0000;
        bif.cfg_we = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b1;
        bif.req      = 4'b0000;
        bif.data1    = 8'h11;
        bif.data2    = 8'h22;
        bif.data3    = 8'h33;
        bif.data4    = 8'h44;
        bif.cfg_we   = 1'b0;
        bif.cfg_mask = 4'b0000;
        #2;
        do_reset();
        #1;
        check_all("reset");

        // Full contention: four tenures of MaxBurst cycles each, then wrap.
        bif.req = 4'b1111;
        tick("rr");
        check("rr.first", 32'(bif.grant), 32'h1);
        for (int n = 1; n < 17; n++) begin
            tick("rr");
            if (n == 1) check("rr.word1", 32'(bif.bus_data), 32'h11);
            if (n == 4) check("rr.second", 32'(bif.grant), 32'h2);
            if (n == 16) check("rr.wrap", 32'(bif.grant), 32'h1);
        end

        // Asynchronous reset while requester 3 owns the bus.
        do_reset();
        bif.req = 4'b1111;
        for (int n = 0; n < 9; n++) tick("pre_rst");
        check("pre_rst.owner", 32'(bif.grant), 32'h4);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        tick("post_rst");
        check("post_rst.first", 32'(bif.grant), 32'h1);

        // Early release hands over with no idle gap.
        do_reset();
        bif.req = 4'b0101;
        tick("early");
        tick("early");
        bif.req = 4'b0100;
        tick("early");
        check("early.handover", 32'(bif.grant), 32'h4);
        check("early.valid", 32'(bif.bus_valid), 32'h1);
        tick("early");

        // Lone requester re-wins its own tenure every MaxBurst cycles.
        do_reset();
        bif.req = 4'b0010;
        for (int n = 0; n < 10; n++) tick("lone");
        check("lone.grant", 32'(bif.grant), 32'h2);

        // Accepted mask write, then an inverted bus word.
        do_reset();
        bif.cfg_we   = 1'b1;
        bif.cfg_mask = 4'b0100;
        tick("mask_wr");
        bif.cfg_we = 1'b0;
        bif.req    = 4'b0100;
        bif.data3  = 8'h0F;
        tick("mask");
        tick("mask");
        check("mask.inverted", 32'(bif.bus_data), 32'hF0);
        bif.req = 4'b0000;
        tick("mask");
        tick("mask");
        check("mask.idle_zero", 32'(bif.bus_data), 32'h00);

        // Rejected mask write while requester 1 is granted.
        bif.req = 4'b0001;
        tick("rej");
        bif.cfg_we   = 1'b1;
        bif.cfg_mask = 4'b1111;
        tick("rej");
        bif.cfg_we = 1'b0;
        check("rej.err", 32'(bif.cfg_err), 32'h1);
        tick("rej");
        check("rej.err_clear", 32'(bif.cfg_err), 32'h0);
        check("rej.raw", 32'(bif.bus_data), 32'h11);

        // Randomized traffic with periodic quiet windows for config writes.
        for (int n = 0; n < 400; n++) begin
            bif.data1    = 8'($urandom);
            bif.data2    = 8'($urandom);
            bif.data3    = 8'($urandom);
            bif.data4    = 8'($urandom);
            bif.req      = ((n % 20) >= 17) ? 4'b0000 : 4'($urandom);
            bif.cfg_we   = ($urandom_range(0, 5) == 0);
            bif.cfg_mask = 4'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/or_bus_arbiter_4.md
Name: or_bus_arbiter_4

Overview:
- Round-robin arbiter and sequencer for a shared NrOfBits-wide OR-gate bus with four requesters, each able to drive the bus.
- Grants exactly one requester at a time and gates the other three inputs to zero, so the OR reduction carries only the owner's word.
- Applies a per-input inversion (bubble) mask from a configuration register and registers the bus result.
- Sits between requesting units and the bus consumer; no idle cycle is required between tenures.

Parameters:
NrOfBits, 8, width of each data input and of bus_data
MaxBurst, 4, maximum consecutive grant cycles per tenure (legal range 1..15)

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i+1
data1  input  NrOfBits  requester 1 data
data2  input  NrOfBits  requester 2 data
data3  input  NrOfBits  requester 3 data
data4  input  NrOfBits  requester 4 data
cfg_we  input  1  write enable for the bubble mask
cfg_mask  input  4  new bubble mask; bit i=1 inverts input i+1
grant  output  4  registered one-hot grant, or all-zero
bus_valid  output  1  bus_data holds a granted word
bus_data  output  NrOfBits  registered OR of gated, mask-processed inputs
cfg_err  output  1  one-cycle pulse: cfg_we rejected

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - grant=0, bus_valid=0, bus_data=0, cfg_err=0.
  - mask=0, priority pointer ptr=0 (requester 1 highest), burst counter=0, FSM=IDLE.
- States: IDLE (grant=0) and BUSY (grant one-hot).
- IDLE:
  - At an edge with req!=0, grant the first set req bit scanning ptr, ptr+1, ... mod 4.
  - Go to BUSY, set burst count=1, set ptr=winner+1 mod 4.
- BUSY, evaluated at each edge with owner o:
  - Hold: req[o]=1 and count<MaxBurst. Keep grant, count+1.
  - End of tenure: req[o]=0 or count=MaxBurst. Re-arbitrate from ptr in the same edge. New winner (may be o only if no other req is set) gets grant immediately, count=1, ptr updated. No requester: grant=0, go to IDLE.
  - A requester dropping req has its grant removed at the next edge. It may see grant high for one cycle with req low; that cycle's data is still forwarded.
- Datapath:
  - gated_i = grant[i] ? (data_i XOR {NrOfBits{mask[i]}}) : 0.
  - Result = gated_1 | gated_2 | gated_3 | gated_4.
  - At each edge: bus_data <= result, bus_valid <= |grant. Latency is one cycle from a grant-high cycle to its bus word.
  - When grant=0, bus_data goes to 0 on the next edge, even when the mask is nonzero.
- Configuration:
  - cfg_we accepted only at an edge where FSM=IDLE and req=0; then mask <= cfg_mask, effective from the next grant.
  - Otherwise mask is unchanged and cfg_err=1 for the following cycle only.
- Simultaneous events: a request from a non-owner never preempts the owner before tenure end. Starvation bound: any held request is granted within 3*MaxBurst cycles.
- Reset mid-tenure: all state clears at once. No bus word is produced for the interrupted cycle.

Test Plan:
- Reset: assert reset_n=0 mid-BUSY with grant=0100 -> all outputs 0 asynchronously. After release, req=1111 -> grant=0001 first.
- Round-robin at MaxBurst=4, req=1111 held, data1..4 = 11,22,33,44 -> each grant held exactly 4 cycles, order 0001,0010,0100,1000,0001. bus_data 11,22,33,44 each delayed one cycle, bus_valid continuous.
- Early release: req=0001 for 2 cycles then 0000, with req=0100 from cycle 0 -> grant 0001 for 2 cycles, then 0100 with no gap. bus_valid never drops.
- Lone requester: req=0010 held 10 cycles at MaxBurst=4 -> grant=0010 continuously, counter restarts every 4 cycles.
- Mask: in IDLE write cfg_mask=0100, then req=0100 with data3=8'h0F -> bus_data=8'hF0. grant=0 afterwards -> bus_data=0.
- Rejected config: cfg_we with grant=0001 -> cfg_err high exactly one cycle, mask unchanged. bus_data equals raw data1.
